// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit. Sequences each instruction through
// IF/ID/EX/MEM/WB, decodes ALU and datapath controls combinationally from the
// current state and instruction, and stalls on the memory ready handshake.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_NOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_SLLV 4'd11
`define ALU_SRLV 4'd12
`define ALU_SRAV 4'd13
`endif

module mc_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic [3:0]  o_aluc,
  output logic [1:0]  o_alusrc_a,
  output logic [1:0]  o_alusrc_b,
  output logic        o_ext_zero,
  output logic        o_pc_we,
  output logic [1:0]  o_pcsrc,
  output logic        o_ir_we,
  output logic        o_iord,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic        o_reg_we,
  output logic [1:0]  o_regdst,
  output logic [1:0]  o_memtoreg,
  output logic        o_illegal,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_q, state_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode            = i_instr[31:26];
  assign funct             = i_instr[5:0];
  assign unused_instr_bits = ^i_instr[25:6];

  // Instruction class decode
  logic       is_rtype, is_ialu, is_mem, is_branch, is_jump;
  logic       funct_ok, is_shamt, ialu_zext, illegal;
  logic [3:0] r_aluc, i_aluc;

  // Decode opcode/funct into instruction class and ALU operation
  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
    is_ialu   = 1'b1;
    ialu_zext = 1'b0;
    i_aluc    = `ALU_ADD;
    case (opcode)
      OP_ADDI, OP_ADDIU: i_aluc = `ALU_ADD;
      OP_SLTI:           i_aluc = `ALU_SLT;
      OP_SLTIU:          i_aluc = `ALU_SLTU;
      OP_ANDI: begin i_aluc = `ALU_AND; ialu_zext = 1'b1; end
      OP_ORI:  begin i_aluc = `ALU_OR;  ialu_zext = 1'b1; end
      OP_XORI: begin i_aluc = `ALU_XOR; ialu_zext = 1'b1; end
      default: is_ialu = 1'b0;
    endcase

    funct_ok = 1'b1;
    is_shamt = 1'b0;
    r_aluc   = `ALU_ADD;
    case (funct)
      6'h20, 6'h21: r_aluc = `ALU_ADD;
      6'h22, 6'h23: r_aluc = `ALU_SUB;
      6'h24:        r_aluc = `ALU_AND;
      6'h25:        r_aluc = `ALU_OR;
      6'h26:        r_aluc = `ALU_XOR;
      6'h27:        r_aluc = `ALU_NOR;
      6'h2A:        r_aluc = `ALU_SLT;
      6'h2B:        r_aluc = `ALU_SLTU;
      6'h00: begin r_aluc = `ALU_SLL; is_shamt = 1'b1; end
      6'h02: begin r_aluc = `ALU_SRL; is_shamt = 1'b1; end
      6'h03: begin r_aluc = `ALU_SRA; is_shamt = 1'b1; end
      6'h04:        r_aluc = `ALU_SLLV;
      6'h06:        r_aluc = `ALU_SRLV;
      6'h07:        r_aluc = `ALU_SRAV;
      default:      funct_ok = 1'b0;
    endcase

    illegal = is_rtype ? !funct_ok
                       : !(is_jump || is_branch || is_mem || is_ialu);
  end

  // State register, forced to IF asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (i_mem_ready) state_d = S_ID;
      S_ID:  state_d = (is_jump || illegal) ? S_IF : S_EX;
      S_EX: begin
        if (is_rtype || is_ialu) state_d = S_WB;
        else if (is_mem)         state_d = S_MEM;
        else                     state_d = S_IF;
      end
      S_MEM: if (i_mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Output decode; everything held at its idle value while reset is low
  always_comb begin
    o_aluc     = `ALU_ADD;
    o_alusrc_a = 2'd0;
    o_alusrc_b = 2'd0;
    o_ext_zero = 1'b0;
    o_pc_we    = 1'b0;
    o_pcsrc    = 2'd0;
    o_ir_we    = 1'b0;
    o_iord     = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_we   = 1'b0;
    o_reg_we   = 1'b0;
    o_regdst   = 2'd0;
    o_memtoreg = 2'd0;
    o_illegal  = 1'b0;
    o_state    = 3'd0;
    if (i_rst_n) begin
      o_state = state_q;
      case (state_q)
        S_IF: begin
          o_mem_re   = 1'b1;
          o_alusrc_b = 2'd1;
          o_ir_we    = i_mem_ready;
          o_pc_we    = i_mem_ready;
        end
        S_ID: begin
          o_alusrc_b = 2'd3;
          if (is_jump) begin
            o_pc_we = 1'b1;
            o_pcsrc = 2'd2;
            if (opcode == OP_JAL) begin
              o_reg_we   = 1'b1;
              o_regdst   = 2'd2;
              o_memtoreg = 2'd2;
            end
          end else if (illegal) begin
            o_illegal = 1'b1;
          end
        end
        S_EX: begin
          if (is_rtype) begin
            o_alusrc_a = is_shamt ? 2'd2 : 2'd1;
            o_aluc     = r_aluc;
          end else if (is_ialu) begin
            o_alusrc_a = 2'd1;
            o_alusrc_b = 2'd2;
            o_aluc     = i_aluc;
            o_ext_zero = ialu_zext;
          end else if (is_mem) begin
            o_alusrc_a = 2'd1;
            o_alusrc_b = 2'd2;
          end else if (is_branch) begin
            o_alusrc_a = 2'd1;
            o_aluc     = `ALU_SUB;
            o_pcsrc    = 2'd1;
            o_pc_we    = (opcode == OP_BEQ) ? i_zero : !i_zero;
          end
        end
        S_MEM: begin
          o_iord   = 1'b1;
          o_mem_re = (opcode == OP_LW);
          o_mem_we = (opcode == OP_SW);
        end
        S_WB: begin
          o_reg_we   = 1'b1;
          o_regdst   = is_rtype ? 2'd1 : 2'd0;
          o_memtoreg = (opcode == OP_LW) ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver applies one directed vector per
// cycle and queues the hand-computed expected outputs; a monitor compares
// them at the falling edge.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_NOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_SLLV 4'd11
`define ALU_SRLV 4'd12
`define ALU_SRAV 4'd13
`endif

module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] aluc;
    logic [1:0] a;
    logic [1:0] b;
    logic       ext;
    logic       pc_we;
    logic [1:0] pcsrc;
    logic       ir_we;
    logic       iord;
    logic       re;
    logic       we;
    logic       reg_we;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  aluc;
  logic [1:0]  alusrc_a, alusrc_b, pcsrc, regdst, memtoreg;
  logic        ext_zero, pc_we, ir_we, iord, mem_re, mem_we, reg_we, illegal;
  logic [2:0]  state;

  mc_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_aluc(aluc), .o_alusrc_a(alusrc_a),
    .o_alusrc_b(alusrc_b), .o_ext_zero(ext_zero), .o_pc_we(pc_we),
    .o_pcsrc(pcsrc), .o_ir_we(ir_we), .o_iord(iord), .o_mem_re(mem_re),
    .o_mem_we(mem_we), .o_reg_we(reg_we), .o_regdst(regdst),
    .o_memtoreg(memtoreg), .o_illegal(illegal), .o_state(state)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  act;

  assign act = {state, aluc, alusrc_a, alusrc_b, ext_zero, pc_we, pcsrc,
                ir_we, iord, mem_re, mem_we, reg_we, regdst, memtoreg, illegal};

  // Monitor: pop and compare one expectation per presented cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", n, act, e);
      end
    end
  end

  function automatic exp_t f_rst();
    exp_t e = '0;
    e.aluc = `ALU_ADD;
    return e;
  endfunction

  function automatic exp_t f_if(input logic r);
    exp_t e = f_rst();
    e.re = 1'b1; e.b = 2'd1; e.ir_we = r; e.pc_we = r;
    return e;
  endfunction

  function automatic exp_t f_id();
    exp_t e = f_rst();
    e.st = 3'd1; e.b = 2'd3;
    return e;
  endfunction

  function automatic exp_t f_ex(input logic [3:0] op, input logic [1:0] a,
                                input logic [1:0] b);
    exp_t e = f_rst();
    e.st = 3'd2; e.aluc = op; e.a = a; e.b = b;
    return e;
  endfunction

  function automatic exp_t f_mem(input logic lw);
    exp_t e = f_rst();
    e.st = 3'd3; e.iord = 1'b1; e.re = lw; e.we = !lw;
    return e;
  endfunction

  function automatic exp_t f_wb(input logic [1:0] rd, input logic [1:0] m2r);
    exp_t e = f_rst();
    e.st = 3'd4; e.reg_we = 1'b1; e.regdst = rd; e.memtoreg = m2r;
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic [31:0] ins, input logic rdy,
                     input logic z, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n = rst; instr = ins; mem_ready = rdy; zero = z;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  initial begin
    exp_t x;
    // reset held
    cyc(1'b0, 32'h0, 1'b1, 1'b0, f_rst(), "reset0");
    cyc(1'b0, 32'h0, 1'b1, 1'b0, f_rst(), "reset1");

    // add r3,r1,r2
    cyc(1'b1, 32'h00221820, 1'b1, 1'b0, f_if(1'b1), "add_if");
    cyc(1'b1, 32'h00221820, 1'b1, 1'b0, f_id(), "add_id");
    cyc(1'b1, 32'h00221820, 1'b1, 1'b0, f_ex(`ALU_ADD, 2'd1, 2'd0), "add_ex");
    cyc(1'b1, 32'h00221820, 1'b1, 1'b0, f_wb(2'd1, 2'd0), "add_wb");

    // sll r2,r1,4
    cyc(1'b1, 32'h00011100, 1'b1, 1'b0, f_if(1'b1), "sll_if");
    cyc(1'b1, 32'h00011100, 1'b1, 1'b0, f_id(), "sll_id");
    cyc(1'b1, 32'h00011100, 1'b1, 1'b0, f_ex(`ALU_SLL, 2'd2, 2'd0), "sll_ex");
    cyc(1'b1, 32'h00011100, 1'b1, 1'b0, f_wb(2'd1, 2'd0), "sll_wb");

    // srav r3,r2,r1 (variable shift takes rs)
    cyc(1'b1, 32'h00221807, 1'b1, 1'b0, f_if(1'b1), "srav_if");
    cyc(1'b1, 32'h00221807, 1'b1, 1'b0, f_id(), "srav_id");
    cyc(1'b1, 32'h00221807, 1'b1, 1'b0, f_ex(`ALU_SRAV, 2'd1, 2'd0), "srav_ex");
    cyc(1'b1, 32'h00221807, 1'b1, 1'b0, f_wb(2'd1, 2'd0), "srav_wb");

    // lw r5,8(r1) with 3 wait cycles in MEM
    cyc(1'b1, 32'h8C250008, 1'b1, 1'b0, f_if(1'b1), "lw_if");
    cyc(1'b1, 32'h8C250008, 1'b1, 1'b0, f_id(), "lw_id");
    cyc(1'b1, 32'h8C250008, 1'b1, 1'b0, f_ex(`ALU_ADD, 2'd1, 2'd2), "lw_ex");
    cyc(1'b1, 32'h8C250008, 1'b0, 1'b0, f_mem(1'b1), "lw_mem_w1");
    cyc(1'b1, 32'h8C250008, 1'b0, 1'b0, f_mem(1'b1), "lw_mem_w2");
    cyc(1'b1, 32'h8C250008, 1'b0, 1'b0, f_mem(1'b1), "lw_mem_w3");
    cyc(1'b1, 32'h8C250008, 1'b1, 1'b0, f_mem(1'b1), "lw_mem_rdy");
    cyc(1'b1, 32'h8C250008, 1'b1, 1'b0, f_wb(2'd0, 2'd1), "lw_wb");

    // ori r1,r2,0x1234 with one fetch wait
    cyc(1'b1, 32'h34411234, 1'b0, 1'b0, f_if(1'b0), "ori_if_wait");
    cyc(1'b1, 32'h34411234, 1'b1, 1'b0, f_if(1'b1), "ori_if");
    cyc(1'b1, 32'h34411234, 1'b1, 1'b0, f_id(), "ori_id");
    x = f_ex(`ALU_OR, 2'd1, 2'd2); x.ext = 1'b1;
    cyc(1'b1, 32'h34411234, 1'b1, 1'b0, x, "ori_ex");
    cyc(1'b1, 32'h34411234, 1'b1, 1'b0, f_wb(2'd0, 2'd0), "ori_wb");

    // slti: sign-extended compare
    cyc(1'b1, 32'h2841FFFF, 1'b1, 1'b0, f_if(1'b1), "slti_if");
    cyc(1'b1, 32'h2841FFFF, 1'b1, 1'b0, f_id(), "slti_id");
    cyc(1'b1, 32'h2841FFFF, 1'b1, 1'b0, f_ex(`ALU_SLT, 2'd1, 2'd2), "slti_ex");
    cyc(1'b1, 32'h2841FFFF, 1'b1, 1'b0, f_wb(2'd0, 2'd0), "slti_wb");

    // beq taken
    cyc(1'b1, 32'h10220004, 1'b1, 1'b1, f_if(1'b1), "beq_if");
    cyc(1'b1, 32'h10220004, 1'b1, 1'b1, f_id(), "beq_id");
    x = f_ex(`ALU_SUB, 2'd1, 2'd0); x.pcsrc = 2'd1; x.pc_we = 1'b1;
    cyc(1'b1, 32'h10220004, 1'b1, 1'b1, x, "beq_ex");

    // bne not taken (zero=1)
    cyc(1'b1, 32'h14220004, 1'b1, 1'b1, f_if(1'b1), "bne_if");
    cyc(1'b1, 32'h14220004, 1'b1, 1'b1, f_id(), "bne_id");
    x = f_ex(`ALU_SUB, 2'd1, 2'd0); x.pcsrc = 2'd1;
    cyc(1'b1, 32'h14220004, 1'b1, 1'b1, x, "bne_ex");

    // bne taken (zero=0)
    cyc(1'b1, 32'h14220004, 1'b1, 1'b0, f_if(1'b1), "bne2_if");
    cyc(1'b1, 32'h14220004, 1'b1, 1'b0, f_id(), "bne2_id");
    x = f_ex(`ALU_SUB, 2'd1, 2'd0); x.pcsrc = 2'd1; x.pc_we = 1'b1;
    cyc(1'b1, 32'h14220004, 1'b1, 1'b0, x, "bne2_ex");

    // j
    cyc(1'b1, 32'h08000010, 1'b1, 1'b0, f_if(1'b1), "j_if");
    x = f_id(); x.pc_we = 1'b1; x.pcsrc = 2'd2;
    cyc(1'b1, 32'h08000010, 1'b1, 1'b0, x, "j_id");

    // jal
    cyc(1'b1, 32'h0C000010, 1'b1, 1'b0, f_if(1'b1), "jal_if");
    x = f_id(); x.pc_we = 1'b1; x.pcsrc = 2'd2;
    x.reg_we = 1'b1; x.regdst = 2'd2; x.memtoreg = 2'd2;
    cyc(1'b1, 32'h0C000010, 1'b1, 1'b0, x, "jal_id");

    // illegal opcode 0x3F
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b0, f_if(1'b1), "ill_op_if");
    x = f_id(); x.ill = 1'b1;
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b0, x, "ill_op_id");

    // illegal funct 0x01
    cyc(1'b1, 32'h00000001, 1'b1, 1'b0, f_if(1'b1), "ill_fn_if");
    x = f_id(); x.ill = 1'b1;
    cyc(1'b1, 32'h00000001, 1'b1, 1'b0, x, "ill_fn_id");

    // sw with zero wait
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_if(1'b1), "sw_if");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_id(), "sw_id");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_ex(`ALU_ADD, 2'd1, 2'd2), "sw_ex");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_mem(1'b0), "sw_mem");

    // sw stalled in MEM, then reset mid-access
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_if(1'b1), "swr_if");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_id(), "swr_id");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_ex(`ALU_ADD, 2'd1, 2'd2), "swr_ex");
    cyc(1'b1, 32'hAC250008, 1'b0, 1'b0, f_mem(1'b0), "swr_mem_w1");
    cyc(1'b1, 32'hAC250008, 1'b0, 1'b0, f_mem(1'b0), "swr_mem_w2");
    cyc(1'b0, 32'hAC250008, 1'b0, 1'b0, f_rst(), "swr_rst0");
    cyc(1'b0, 32'hAC250008, 1'b1, 1'b0, f_rst(), "swr_rst1");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_if(1'b1), "swr_refetch");
    cyc(1'b1, 32'hAC250008, 1'b1, 1'b0, f_id(), "swr_id2");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sits upstream of the ALU and drives the ALU's 4-bit `i_aluc` code and its operand selects, plus register-file, memory and PC strobes. It sequences each instruction through a 5-state FSM and stalls on a memory ready handshake.

## Interface
- No parameters. ALU codes are the shared `ALU_*` macros from `macro.vh`; state encodings are local.
- `i_clk  in  1`  clock, rising-edge.
- `i_rst_n  in  1`  reset, asynchronous, active-low.
- `i_instr  in  32`  instruction register contents; opcode [31:26], funct [5:0].
- `i_zero  in  1`  ALU result == 0, from the datapath.
- `i_mem_ready  in  1`  memory access complete this cycle.
- `o_aluc  out  4`  ALU operation code.
- `o_alusrc_a  out  2`  ALU A operand: 0 = PC, 1 = A reg (rs), 2 = zero-extended shamt.
- `o_alusrc_b  out  2`  ALU B operand: 0 = B reg (rt), 1 = constant 4, 2 = extended imm, 3 = sign-extended imm << 2.
- `o_ext_zero  out  1`  immediate is zero-extended when 1, sign-extended when 0.
- `o_pc_we  out  1`  PC write enable.
- `o_pcsrc  out  2`  next PC: 0 = ALU result, 1 = ALUOut reg, 2 = jump target.
- `o_ir_we  out  1`  IR write enable.
- `o_iord  out  1`  memory address: 0 = PC, 1 = ALUOut.
- `o_mem_re`, `o_mem_we  out  1`  memory read and write strobes.
- `o_reg_we  out  1`  register file write enable.
- `o_regdst  out  2`  write register: 0 = rt, 1 = rd, 2 = r31.
- `o_memtoreg  out  2`  write data: 0 = ALUOut, 1 = MDR, 2 = PC.
- `o_illegal  out  1`  one-cycle pulse when an unsupported opcode or funct is decoded.
- `o_state  out  3`  current state, for debug.

## Operation
- States: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4. Outputs are decoded combinationally from the state and `i_instr`.
- Every strobe not listed for a state is 0. Default `o_aluc` is `ALU_ADD`.
- **IF**
  - Drives `o_mem_re`=1, `o_iord`=0, A=PC, B=4, ADD, `o_pcsrc`=0.
  - If `i_mem_ready`: `o_ir_we`=1, `o_pc_we`=1, go to ID. Otherwise stay in IF.
- **ID** (A=PC, B=imm<<2, ADD; branch target is latched into ALUOut)
  - j (0x02): `o_pc_we`=1, `o_pcsrc`=2, go to IF.
  - jal (0x03): as j, plus `o_reg_we`=1, `o_regdst`=2, `o_memtoreg`=2.
  - Illegal opcode, or illegal funct when opcode = 0x00: `o_illegal`=1, go to IF.
  - Anything else: go to EX.
- **EX**
  - R-type (0x00): A=1, or A=2 for sll/srl/sra; B=0; `o_aluc` from funct. Go to WB.
  - Funct map: 0x20/0x21→ADD, 0x22/0x23→SUB, 0x24→AND, 0x25→OR, 0x26→XOR, 0x27→NOR, 0x2A→SLT, 0x2B→SLTU, 0x00→SLL, 0x02→SRL, 0x03→SRA, 0x04→SLLV, 0x06→SRLV, 0x07→SRAV.
  - I-ALU: A=1, B=2. addi 0x08 / addiu 0x09→ADD, slti 0x0A→SLT, sltiu 0x0B→SLTU use sign extension. andi 0x0C→AND, ori 0x0D→OR, xori 0x0E→XOR set `o_ext_zero`=1. Go to WB.
  - lw 0x23 / sw 0x2B: A=1, B=2, ADD. Go to MEM.
  - beq 0x04 / bne 0x05: A=1, B=0, SUB, `o_pcsrc`=1. `o_pc_we` = `i_zero` for beq, !`i_zero` for bne. Go to IF.
- **MEM**
  - `o_iord`=1. lw drives `o_mem_re`=1; sw drives `o_mem_we`=1. Strobes hold until `i_mem_ready`.
  - On ready: lw goes to WB, sw goes to IF.
- **WB**
  - `o_reg_we`=1. `o_regdst`=1 for R-type, 0 otherwise. `o_memtoreg`=1 for lw, 0 otherwise. Go to IF.

## Timing
- Reset: the state register is forced to IF asynchronously. While `i_rst_n`=0 every strobe is gated to 0, `o_aluc`=`ALU_ADD`, all selects are 0, and `o_state`=0.
- After reset release, the first IF fetch is issued in the same cycle.
- Reset mid-instruction: no write enables occur after the asserting edge; the instruction restarts at IF with the current PC.
- Latency with zero wait states (`i_mem_ready`=1): R-type and I-ALU 4 cycles, lw 5, sw 4, beq/bne 3, j/jal 2, illegal 2.
- Each cycle of low `i_mem_ready` in IF or MEM adds one cycle. Strobes and address select stay stable while waiting.
- `i_instr` must be stable from ID through WB. The IR is written only at the IF→ID transition.
- `o_illegal` is exactly one cycle wide, in ID.

## Test plan
- Reset is asserted mid-MEM of an sw with `i_mem_ready`=0 → `o_mem_we` drops immediately, `o_state`=0 at release, no register write.
- add r3,r1,r2 (0x00221820), ready always 1 → states 0,1,2,4 then 0. EX shows `ALU_ADD` with A=1, B=0. WB shows `o_reg_we`=1, `o_regdst`=1.
- sll r2,r1,4 (0x00011100) → EX shows `o_aluc`=`ALU_SLL`, `o_alusrc_a`=2, `o_alusrc_b`=0.
- lw r5,8(r1) (0x8C250008) with `i_mem_ready` low for 3 MEM cycles → `o_mem_re`/`o_iord` held 3+1 cycles, then WB with `o_memtoreg`=1, `o_regdst`=0. Total 8 cycles.
- beq with `i_zero`=1 → EX `o_pc_we`=1, `o_pcsrc`=1. bne with `i_zero`=1 → EX `o_pc_we`=0. Both return to IF after 3 cycles.
- Opcode 0x3F, and funct 0x01 under opcode 0x00 → `o_illegal` pulses in ID, no `o_reg_we`/`o_mem_we`, next state IF.
